// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
package pc_seq_pkg;

    localparam int PC_W      = 12;
    localparam int LUT_IDX_W = 6;

    // Relative-branch offsets selected by branch_idx; any other index gives 0.
    localparam int BR_OFF_0 = -5;
    localparam int BR_OFF_1 = 20;
    localparam int BR_OFF_2 = -1;
    localparam int BR_OFF_3 = -20;
    localparam int BR_OFF_4 = -3;
    localparam int BR_OFF_5 = 2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALTED
    } seq_state_t;

endpackage

// File: rtl/rel_target_lut.sv
// Relative-branch LUT: maps a branch index to a signed D-bit PC offset.
module rel_target_lut
    import pc_seq_pkg::*;
#(
    parameter int D = PC_W
) (
    input  logic        [LUT_IDX_W-1:0] idx_i,
    output logic signed [D-1:0]         offset_o
);

    // Pure table lookup; unlisted indices give offset 0 (a taken branch self-loops).
    always_comb begin
        offset_o = '0;
        case (idx_i)
            LUT_IDX_W'(0): offset_o = D'(BR_OFF_0);
            LUT_IDX_W'(1): offset_o = D'(BR_OFF_1);
            LUT_IDX_W'(2): offset_o = D'(BR_OFF_2);
            LUT_IDX_W'(3): offset_o = D'(BR_OFF_3);
            LUT_IDX_W'(4): offset_o = D'(BR_OFF_4);
            LUT_IDX_W'(5): offset_o = D'(BR_OFF_5);
            default:       offset_o = '0;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: owns the PC, a small return stack and run control.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int             D        = PC_W,
    parameter logic [D-1:0]   START_PC = '0,
    parameter int             RS_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stall,
    input  logic                 branch_en,
    input  logic [LUT_IDX_W-1:0] branch_idx,
    input  logic                 abs_jump,
    input  logic                 call_en,
    input  logic                 ret_en,
    input  logic [D-1:0]         abs_target,
    input  logic                 halt_req,
    output logic [D-1:0]         pc,
    output logic                 fetch_valid,
    output logic                 done,
    output logic                 stack_err
);

    // Stack pointer counts entries 0..RS_DEPTH, so it needs one bit beyond the index.
    localparam int             IDX_W   = $clog2(RS_DEPTH);
    localparam int             SP_W    = IDX_W + 1;
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(RS_DEPTH);

    seq_state_t        state_q, state_d;
    logic [D-1:0]      pc_q, pc_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic              err_q, err_d;
    logic              push_en;
    logic [D-1:0]      pc_inc;
    logic [IDX_W-1:0]  top_idx;
    logic signed [D-1:0] br_offset;
    logic [D-1:0]      stack_q [RS_DEPTH];

    rel_target_lut #(
        .D(D)
    ) u_lut (
        .idx_i    (branch_idx),
        .offset_o (br_offset)
    );

    // Wraps modulo 2^D naturally; also the return address pushed by a call.
    assign pc_inc  = pc_q + D'(1);
    // Index of the most recent entry; only meaningful when sp_q != 0.
    assign top_idx = sp_q[IDX_W-1:0] - IDX_W'(1);

    // Control state register: FSM, PC, stack pointer and sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= START_PC;
            sp_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            sp_q    <= sp_d;
            err_q   <= err_d;
        end
    end

    // Return-stack storage; contents are don't-care once the pointer is cleared.
    always_ff @(posedge clk) begin
        if (push_en && !reset) begin
            stack_q[sp_q[IDX_W-1:0]] <= pc_inc;
        end
    end

    // Next-state logic: run control first, then one PC action by priority.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        sp_d    = sp_q;
        err_d   = err_q;
        push_en = 1'b0;
        case (state_q)
            IDLE, HALTED: begin
                if (start) begin
                    state_d = RUN;
                    pc_d    = START_PC;
                    sp_d    = '0;
                    err_d   = 1'b0;
                end
            end
            RUN: begin
                if (halt_req) begin
                    state_d = HALTED;
                end else if (!stall) begin
                    if (ret_en) begin
                        if (sp_q == '0) begin
                            err_d   = 1'b1;
                            state_d = HALTED;
                        end else begin
                            pc_d = stack_q[top_idx];
                            sp_d = sp_q - SP_W'(1);
                        end
                    end else if (call_en) begin
                        if (sp_q == SP_FULL) begin
                            err_d   = 1'b1;
                            state_d = HALTED;
                        end else begin
                            push_en = 1'b1;
                            pc_d    = abs_target;
                            sp_d    = sp_q + SP_W'(1);
                        end
                    end else if (abs_jump) begin
                        pc_d = abs_target;
                    end else if (branch_en) begin
                        pc_d = pc_q + $unsigned(br_offset);
                    end else begin
                        pc_d = pc_inc;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                pc_d    = START_PC;
                sp_d    = '0;
                err_d   = 1'b0;
            end
        endcase
    end

    assign pc          = pc_q;
    assign fetch_valid = (state_q == RUN) && !stall;
    assign done        = (state_q == HALTED);
    assign stack_err   = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: behavioural model plus directed literals.
module tb_pc_sequencer;

    localparam int D     = 12;
    localparam int DEPTH = 4;
    localparam int MODN  = 4096;

    logic          clk = 1'b0;
    logic          reset, start, stall, branch_en, abs_jump, call_en, ret_en, halt_req;
    logic [5:0]    branch_idx;
    logic [D-1:0]  abs_target;
    logic [D-1:0]  pc;
    logic          fetch_valid, done, stack_err;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Model state: mode 0 = idle, 1 = running, 2 = halted.
    int m_mode = 0;
    int m_pc   = 0;
    int m_rs[$];
    bit m_err  = 1'b0;

    pc_sequencer #(
        .D        (D),
        .START_PC (12'h000),
        .RS_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stall       (stall),
        .branch_en   (branch_en),
        .branch_idx  (branch_idx),
        .abs_jump    (abs_jump),
        .call_en     (call_en),
        .ret_en      (ret_en),
        .abs_target  (abs_target),
        .halt_req    (halt_req),
        .pc          (pc),
        .fetch_valid (fetch_valid),
        .done        (done),
        .stack_err   (stack_err)
    );

    always #5 clk = ~clk;

    function automatic int offset_of(input int idx);
        case (idx)
            0: return -5;
            1: return 20;
            2: return -1;
            3: return -20;
            4: return -3;
            5: return 2;
            default: return 0;
        endcase
    endfunction

    function automatic int wrap(input int v);
        return ((v % MODN) + MODN) % MODN;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctl();
        start = 0; stall = 0; branch_en = 0; branch_idx = 0;
        abs_jump = 0; call_en = 0; ret_en = 0; halt_req = 0; abs_target = 0;
    endtask

    // Reference behaviour evaluated on each rising edge.
    always @(posedge clk) begin
        if (reset) begin
            m_mode = 0; m_pc = 0; m_rs.delete(); m_err = 0;
        end else if (m_mode != 1) begin
            if (start) begin
                m_mode = 1; m_pc = 0; m_rs.delete(); m_err = 0;
            end
        end else if (halt_req) begin
            m_mode = 2;
        end else if (!stall) begin
            if (ret_en) begin
                if (m_rs.size() == 0) begin
                    m_err = 1; m_mode = 2;
                end else begin
                    m_pc = m_rs.pop_back();
                end
            end else if (call_en) begin
                if (m_rs.size() == DEPTH) begin
                    m_err = 1; m_mode = 2;
                end else begin
                    m_rs.push_back(wrap(m_pc + 1));
                    m_pc = int'(abs_target);
                end
            end else if (abs_jump) begin
                m_pc = int'(abs_target);
            end else if (branch_en) begin
                m_pc = wrap(m_pc + offset_of(int'(branch_idx)));
            end else begin
                m_pc = wrap(m_pc + 1);
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_pc",   int'(pc),          m_pc);
            check("model_fv",   int'(fetch_valid), int'((m_mode == 1) && !stall));
            check("model_done", int'(done),        int'(m_mode == 2));
            check("model_err",  int'(stack_err),   int'(m_err));
        end
    end

    initial begin
        clear_ctl();
        reset = 1;
        step();
        chk_en = 1;
        step();
        check("reset_pc", int'(pc), 0);
        check("reset_fv", int'(fetch_valid), 0);
        check("reset_done", int'(done), 0);
        check("reset_err", int'(stack_err), 0);
        reset = 0;

        // Idle ignores everything but start.
        branch_en = 1; branch_idx = 1; abs_jump = 1; abs_target = 12'h123;
        step();
        check("idle_hold", int'(pc), 0);
        clear_ctl();

        // Start and free-run increments.
        start = 1; step(); start = 0;
        check("start_pc", int'(pc), 0);
        check("start_fv", int'(fetch_valid), 1);
        check("start_done", int'(done), 0);
        for (int i = 1; i <= 4; i++) begin
            step();
            check("incr_pc", int'(pc), i);
        end

        // Relative branches through the LUT, with wrap in both directions.
        branch_en = 1;
        branch_idx = 0; step(); check("br_idx0", int'(pc), 12'hFFF);
        branch_idx = 1; step(); check("br_idx1", int'(pc), 12'h013);
        branch_idx = 7; step(); check("br_idx7", int'(pc), 12'h013);
        branch_idx = 2; step(); check("br_idx2", int'(pc), 12'h012);
        branch_idx = 3; step(); check("br_idx3", int'(pc), 12'hFFE);
        branch_idx = 4; step(); check("br_idx4", int'(pc), 12'hFFB);
        branch_idx = 5; step(); check("br_idx5", int'(pc), 12'hFFD);
        branch_en = 0;
        step(); step(); step();
        check("incr_wrap", int'(pc), 12'h000);

        // Jump, call, return.
        abs_jump = 1; abs_target = 12'h010; step(); abs_jump = 0;
        check("jump", int'(pc), 12'h010);
        call_en = 1; abs_target = 12'h100; step(); call_en = 0;
        check("call", int'(pc), 12'h100);
        step(); step(); step();
        check("callee_run", int'(pc), 12'h103);
        ret_en = 1; step(); ret_en = 0;
        check("ret", int'(pc), 12'h011);

        // Priority: ret over call, jump over branch, call over jump.
        call_en = 1; abs_target = 12'h100; step();
        ret_en = 1; step(); clear_ctl();
        check("ret_beats_call", int'(pc), 12'h012);
        abs_jump = 1; branch_en = 1; branch_idx = 1; abs_target = 12'h050; step(); clear_ctl();
        check("jump_beats_br", int'(pc), 12'h050);
        call_en = 1; abs_jump = 1; abs_target = 12'h200; step(); clear_ctl();
        check("call_beats_jump", int'(pc), 12'h200);
        ret_en = 1; step(); clear_ctl();
        check("ret_after_pri", int'(pc), 12'h051);

        // Underflow.
        ret_en = 1; step(); clear_ctl();
        check("uflow_err", int'(stack_err), 1);
        check("uflow_done", int'(done), 1);
        check("uflow_pc", int'(pc), 12'h051);
        check("uflow_fv", int'(fetch_valid), 0);
        branch_en = 1; step(); clear_ctl();
        check("halted_hold", int'(pc), 12'h051);
        start = 1; step(); start = 0;
        check("restart_pc", int'(pc), 0);
        check("restart_err", int'(stack_err), 0);

        // LIFO order.
        call_en = 1; abs_target = 12'h100; step();
        abs_target = 12'h200; step(); clear_ctl();
        ret_en = 1; step();
        check("lifo_1", int'(pc), 12'h101);
        step(); clear_ctl();
        check("lifo_2", int'(pc), 12'h001);

        // Overflow on the fifth nested call.
        for (int i = 0; i < 5; i++) begin
            call_en = 1; abs_target = D'(12'h100 + 16 * i); step();
        end
        clear_ctl();
        check("oflow_err", int'(stack_err), 1);
        check("oflow_done", int'(done), 1);
        start = 1; step(); start = 0;
        check("oflow_restart_pc", int'(pc), 0);
        check("oflow_restart_err", int'(stack_err), 0);

        // Stall holds everything and drops fetch_valid.
        step(); step();
        stall = 1; branch_en = 1; branch_idx = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_pc", int'(pc), 2);
            check("stall_fv", int'(fetch_valid), 0);
        end
        clear_ctl();
        step();
        check("post_stall", int'(pc), 3);

        // Halt beats stall; halt beats a branch.
        halt_req = 1; stall = 1; step(); clear_ctl();
        check("halt_stall_done", int'(done), 1);
        check("halt_stall_pc", int'(pc), 3);
        start = 1; step(); start = 0;
        step(); step();
        halt_req = 1; branch_en = 1; branch_idx = 1; step(); clear_ctl();
        check("halt_br_pc", int'(pc), 2);
        check("halt_br_done", int'(done), 1);

        // Reset mid-run and mid-stall.
        start = 1; step(); start = 0;
        step();
        reset = 1; step(); reset = 0;
        check("rst_run_pc", int'(pc), 0);
        check("rst_run_fv", int'(fetch_valid), 0);
        check("rst_run_done", int'(done), 0);
        start = 1; step(); start = 0;
        step();
        stall = 1; step();
        reset = 1; step(); reset = 0; stall = 0;
        check("rst_stall_pc", int'(pc), 0);
        check("rst_stall_fv", int'(fetch_valid), 0);
        step();
        check("rst_stays_idle", int'(fetch_valid), 0);

        chk_en = 0;
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
